// File: rtl/ppu_vga_out.sv
// ppu_vga_out: captures the PPU 256x240 pixel stream into a frame buffer and replays it as a 2x-scaled, centred 640x480 VGA raster; define PPU_VGA_SCANLINES_EN to halve intensity on odd lines
module ppu_vga_out #(
   parameter int          CLK_DIV    = 2,
   parameter int          H_VIS      = 640,
   parameter int          H_FP       = 16,
   parameter int          H_SYNC     = 96,
   parameter int          H_BP       = 48,
   parameter int          V_VIS      = 480,
   parameter int          V_FP       = 10,
   parameter int          V_SYNC     = 2,
   parameter int          V_BP       = 33,
   parameter int          X_OFFSET   = 64,
   parameter logic [5:0]  BORDER_IDX = 6'h0F
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PIX_WE,
   input  logic       PIX_VIS,
   input  logic [7:0] PPU_PTR_X,
   input  logic [7:0] PPU_PTR_Y,
   input  logic [5:0] VGA_STREAM_DATA,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_TICK,
   output logic       VGA_FRAME
);
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DW    = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   // NES colour index to RGB, entry 'h3F first down to 'h00 last
   localparam logic [63:0][23:0] PALETTE = {
      24'h000000, 24'h000000, 24'hB8B8B8, 24'hB5EBF2, 24'hB3F3CC, 24'hBDF4AB, 24'hCFEF96, 24'hE4E594,
      24'hF7D8A5, 24'hFECCC5, 24'hFEC4EA, 24'hFBC2FF, 24'hE8C8FF, 24'hD3D2FF, 24'hC0DFFF, 24'hFFFEFF,
      24'h000000, 24'h000000, 24'h4F4F4F, 24'h48CDDE, 24'h45E082, 24'h5CE430, 24'h88D800, 24'hBCBE00,
      24'hEA9E22, 24'hFE8170, 24'hFE6ECC, 24'hF36AFF, 24'hC676FF, 24'h9290FF, 24'h64B0FF, 24'hFFFEFF,
      24'h000000, 24'h000000, 24'h000000, 24'h007C8D, 24'h008F32, 24'h0C9300, 24'h388700, 24'h6B6D00,
      24'h994E00, 24'hB53120, 24'hB71E7B, 24'hA01ACC, 24'h7527FE, 24'h4240FF, 24'h155FD9, 24'hADADAD,
      24'h000000, 24'h000000, 24'h000000, 24'h00404D, 24'h004F08, 24'h005200, 24'h0B4800, 24'h333500,
      24'h561D00, 24'h6C0600, 24'h6E0040, 24'h5C007E, 24'h3B00A4, 24'h1412A7, 24'h002A88, 24'h666666};

   logic [DW-1:0] div_q, div_d;
   logic          tick;
   logic [9:0]    h_q, h_d, v_q, v_d;
   logic          frame_q, frame_d;
   logic          vis0, img0, hs0, vs0, we;
   logic [7:0]    hx;
   logic [15:0]   raddr;
   logic          vis1_q, img1_q, hsa1_q, vsa1_q;
   logic [5:0]    fb_q, idx;
   logic [23:0]   pal, rgb_d, rgb_q;
   logic          hs_q, vs_q, blank_q;
   logic [5:0]    mem [0:61439] = '{default: BORDER_IDX};
`ifdef PPU_VGA_SCANLINES_EN
   logic          odd1_q;
`endif

   // pixel-tick divider and raster counters; FRAME marks the tick that wraps to (0,0)
   always_comb begin
      tick    = div_q == DW'(CLK_DIV - 1);
      div_d   = tick ? '0 : div_q + DW'(1);
      h_d     = !tick ? h_q : h_q == 10'(H_TOT - 1) ? '0 : h_q + 10'd1;
      v_d     = (!tick || h_q != 10'(H_TOT - 1)) ? v_q : v_q == 10'(V_TOT - 1) ? '0 : v_q + 10'd1;
      frame_d = tick ? (h_q == 10'(H_TOT - 1) && v_q == 10'(V_TOT - 1)) : frame_q;
   end

   // stage 0: decode raster position into visibility, sync and buffer address
   always_comb begin
      vis0  = h_q < 10'(H_VIS) && v_q < 10'(V_VIS);
      img0  = vis0 && h_q >= 10'(X_OFFSET) && h_q < 10'(X_OFFSET + 512);
      hs0   = h_q >= 10'(H_VIS + H_FP) && h_q < 10'(H_VIS + H_FP + H_SYNC);
      vs0   = v_q >= 10'(V_VIS + V_FP) && v_q < 10'(V_VIS + V_FP + V_SYNC);
      hx    = 8'(h_q[9:1] - 9'(X_OFFSET / 2));
      raddr = {v_q[8:1], hx};
      we    = PIX_WE && PIX_VIS && PPU_PTR_Y < 8'd240 && !RST;
   end

   // frame buffer: PPU writes any cycle, raster reads once per tick (old data on collision)
   always_ff @(posedge CLK) begin
      if (we) mem[{PPU_PTR_Y, PPU_PTR_X}] <= VGA_STREAM_DATA;
      fb_q <= RST ? '0 : (tick && img0) ? mem[raddr] : fb_q;
   end

   // stage 2: border substitution, palette lookup and blanking
   always_comb begin
      idx = img1_q ? fb_q : BORDER_IDX;
      pal = PALETTE[idx];
`ifdef PPU_VGA_SCANLINES_EN
      rgb_d = !vis1_q ? '0 : odd1_q ? (pal >> 1) & 24'h7F7F7F : pal;
`else
      rgb_d = vis1_q ? pal : '0;
`endif
   end

   // counters every clock, pipeline stages only on ticks; sync flags kept active-high internally
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= 1'b0;
         vis1_q  <= 1'b0;
         img1_q  <= 1'b0;
         hsa1_q  <= 1'b0;
         vsa1_q  <= 1'b0;
`ifdef PPU_VGA_SCANLINES_EN
         odd1_q  <= 1'b0;
`endif
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         rgb_q   <= '0;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
         if (tick) begin
            vis1_q  <= vis0;
            img1_q  <= img0;
            hsa1_q  <= hs0;
            vsa1_q  <= vs0;
`ifdef PPU_VGA_SCANLINES_EN
            odd1_q  <= v_q[0];
`endif
            hs_q    <= !hsa1_q;
            vs_q    <= !vsa1_q;
            blank_q <= vis1_q;
            rgb_q   <= rgb_d;
         end
      end
   end

   assign VGA_TICK    = tick;
   assign VGA_FRAME   = frame_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_q;
   assign {VGA_R, VGA_G, VGA_B} = rgb_q;
endmodule

// File: tb/tb_ppu_vga_out.sv
// tb_ppu_vga_out: scoreboard bench for ppu_vga_out on a reduced-height raster (12 lines, 8 visible)
module tb_ppu_vga_out;
   localparam int HT = 800, VT = 12, FT = HT * VT;
`ifdef PPU_VGA_SCANLINES_EN
   localparam bit SCAN = 1'b1;
`else
   localparam bit SCAN = 1'b0;
`endif
   localparam logic [27:0] M_ALL = 28'hFFFFFFF, M_NOFR = 28'hEFFFFFF, M_FR = 28'h1000000;

   typedef struct {
      int          at;
      string       name;
      logic [27:0] want;
      logic [27:0] mask;
   } exp_t;

   logic       CLK = 1'b0, RST = 1'b1, PIX_WE = 1'b0, PIX_VIS = 1'b0;
   logic [7:0] PPU_PTR_X = '0, PPU_PTR_Y = '0;
   logic [5:0] VGA_STREAM_DATA = '0;
   logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_TICK, VGA_FRAME;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic [27:0] bus;
   exp_t  sb[$];
   int    checks = 0, errors = 0, ticks = 0, p;
   logic  adv = 1'b0;
   bit    stalled = 1'b0;

   always #5 CLK = ~CLK;

   ppu_vga_out #(.V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut (
      .CLK(CLK), .RST(RST), .PIX_WE(PIX_WE), .PIX_VIS(PIX_VIS),
      .PPU_PTR_X(PPU_PTR_X), .PPU_PTR_Y(PPU_PTR_Y), .VGA_STREAM_DATA(VGA_STREAM_DATA),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_TICK(VGA_TICK), .VGA_FRAME(VGA_FRAME));

   assign bus = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_FRAME, VGA_R, VGA_G, VGA_B};

   always @(posedge CLK) begin
      adv   <= !RST && VGA_TICK;
      ticks <= RST ? 0 : ticks + int'(VGA_TICK);
   end

   function automatic int pos(int f, int h, int v);
      return f * FT + v * HT + h;
   endfunction

   function automatic logic [23:0] sc(logic [23:0] c, int v);
      return (SCAN && v % 2 == 1) ? (c >> 1) & 24'h7F7F7F : c;
   endfunction

   task automatic compare(string name, logic [27:0] got, logic [27:0] want, logic [27:0] mask);
      checks++;
      if (((got ^ want) & mask) != 0) begin
         errors++;
         $display("FAIL %s got %h want %h mask %h", name, got, want, mask);
      end
   endtask

   task automatic expect_at(int at, string name, logic [27:0] want, logic [27:0] mask);
      sb.push_back('{at, name, want, mask});
   endtask

   task automatic px(int f, int h, int v, logic [23:0] rgb, string name);
      expect_at(pos(f, h, v) + 2, name, {4'b1110, sc(rgb, v)}, M_ALL);
   endtask

   task automatic sync(int h, int v, logic hs, logic vs, logic bl, string name);
      expect_at(pos(0, h, v) + 2, name, {hs, vs, bl, 1'b0, 24'h0}, M_NOFR);
   endtask

   task automatic wait_ticks(int target);
      int n = 0;
      while (ticks < target && !stalled) begin
         @(negedge CLK);
         n++;
         if (n > 50000) begin
            stalled = 1'b1;
            checks++;
            errors++;
            $display("FAIL tick_timeout ticks %0d want %0d", ticks, target);
         end
      end
   endtask

   task automatic wr(int x, int y, logic [5:0] d, logic vis);
      PPU_PTR_X = 8'(x);
      PPU_PTR_Y = 8'(y);
      VGA_STREAM_DATA = d;
      PIX_VIS = vis;
      PIX_WE = 1'b1;
      @(negedge CLK);
   endtask

   // monitor: on every pixel tick, retire the expectations due at this tick
   always @(negedge CLK) begin
      if (adv) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at < ticks) begin
               checks++;
               errors++;
               $display("FAIL %s missed at %0d now %0d", sb[i].name, sb[i].at, ticks);
               sb.delete(i);
            end else if (sb[i].at == ticks) begin
               compare(sb[i].name, bus, sb[i].want, sb[i].mask);
               sb.delete(i);
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      compare("reset_pins", bus, {4'b1100, 24'h0}, M_ALL);
      compare("reset_tick", {27'h0, VGA_TICK}, 28'h0, 28'h1);
      RST = 1'b0;
      @(negedge CLK);
      compare("pre_tick_pins", bus, {4'b1100, 24'h0}, M_ALL);
      compare("first_tick", {27'h0, VGA_TICK}, 28'h1, 28'h1);
      expect_at(1, "flush_tick1", {4'b1100, 24'h0}, M_ALL);
      sync(639, 0, 1, 1, 1, "blank_639");
      sync(640, 0, 1, 1, 0, "blank_640");
      sync(655, 0, 1, 1, 0, "hs_655");
      sync(656, 0, 0, 1, 0, "hs_656");
      sync(751, 0, 0, 1, 0, "hs_751");
      sync(752, 0, 1, 1, 0, "hs_752");
      sync(0, 8, 1, 1, 0, "vs_line8");
      sync(0, 9, 1, 0, 0, "vs_line9");
      sync(799, 10, 1, 0, 0, "vs_line10");
      sync(0, 11, 1, 1, 0, "vs_line11");
      expect_at(FT - 1, "frame_before", 28'h0, M_FR);
      expect_at(FT, "frame_pulse", M_FR, M_FR);
      expect_at(FT + 1, "frame_after", 28'h0, M_FR);
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 256; x++) wr(x, y, 6'h0F, 1'b1);
      wr(0, 0, 6'h30, 1'b1);
      wr(255, 3, 6'h16, 1'b1);
      wr(5, 1, 6'h30, 1'b0);
      wr(6, 245, 6'h30, 1'b1);
      PIX_WE = 1'b0;
      px(1, 64, 0, 24'hFFFEFF, "tl_64_0");
      px(1, 65, 0, 24'hFFFEFF, "tl_65_0");
      px(1, 64, 1, 24'hFFFEFF, "tl_64_1");
      px(1, 65, 1, 24'hFFFEFF, "tl_65_1");
      px(1, 63, 0, 24'h000000, "col63");
      px(1, 66, 0, 24'h000000, "tl_right");
      px(1, 64, 2, 24'h000000, "tl_below");
      px(1, 74, 2, 24'h000000, "vis_low_filter");
      px(1, 75, 3, 24'h000000, "vis_low_filter_b");
      px(1, 76, 0, 24'h000000, "y245_filter");
      px(1, 574, 6, 24'hB53120, "br_574_6");
      px(1, 575, 7, 24'hB53120, "br_575_7");
      px(1, 573, 6, 24'h000000, "br_left");
      px(1, 576, 6, 24'h000000, "col576");
      px(1, 264, 4, 24'h000000, "collide_old");
      px(1, 265, 4, 24'hFFFEFF, "collide_new");
      px(1, 264, 5, 24'hFFFEFF, "collide_line5");
      p = pos(1, 264, 4);
      wait_ticks(p);
      if (ticks == p && !VGA_TICK) @(negedge CLK);
      compare("collide_align", {27'h0, ticks == p && VGA_TICK}, 28'h1, 28'h1);
      wr(100, 2, 6'h30, 1'b1);
      PIX_WE = 1'b0;
      wait_ticks(pos(1, 0, 8));
      for (int x = 0; x < 256; x++) wr(x, 3, 6'h30, 1'b1);
      PIX_WE = 1'b0;
      px(2, 64, 0, 24'hFFFEFF, "tl_hold");
      px(2, 264, 4, 24'hFFFEFF, "collide_next");
      px(2, 64, 6, 24'hFFFEFF, "scan_even");
      px(2, 64, 7, 24'hFFFEFF, "scan_odd");
      px(2, 575, 7, 24'hFFFEFF, "row3_fill");
      expect_at(2 * FT, "frame_pulse2", M_FR, M_FR);
      wait_ticks(pos(2, 600, 7) + 2);
      @(negedge CLK);
      foreach (sb[i]) begin
         checks++;
         errors++;
         $display("FAIL %s never checked at %0d", sb[i].name, sb[i].at);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
